mem_stage: RTL and testbench

Memory-stage controller for the five-stage MIPS pipeline. It consumes the EX/MEM latch outputs, drives the data-side cache request, holds the pipeline while the request is outstanding, and registers the result into the MEM/WB boundary. It also owns the sticky halt indication seen by the system.

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_stage_link_reg.sv | 27 ++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, opcodes and the MEM-stage state encoding.
package cpu_types_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [4:0]        regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    JAL   = 6'b000011,
    BEQ   = 6'b000100,
    ADDI  = 6'b001000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000,
    HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [1:0] {RUN, WAIT, HALTED} memstate_t;

  localparam regbits_t LINK_REGNUM = 5'd31;
endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request bus between the memory stage (master) and the cache (slave).
interface mem_stage_if #(parameter int unsigned ADDR_W = 32);
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [ADDR_W-1:0] dmemstore;
  logic              dhit;
  logic [ADDR_W-1:0] dmemload;

  modport master (output dmemREN, dmemWEN, dmemaddr, dmemstore,
                  input  dhit, dmemload);
  modport slave  (input  dmemREN, dmemWEN, dmemaddr, dmemstore,
                  output dhit, dmemload);
endinterface

// File: rtl/mem_stage_link_reg.sv
// LL/SC reservation: a valid bit plus the linked word address.
module link_reg #(parameter int unsigned ADDR_W = 32) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_set,
  input  logic              i_clr,
  input  logic              i_clr_match,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_match
);
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end else if (i_clr || (i_clr_match && r_addr == i_addr)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_match = r_valid && (r_addr == i_addr);
endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-cache request, pipeline hold, MEM/WB register and sticky halt.
// Define MEM_STAGE_LLSC_EN to build in the LL/SC link register.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] pcplus4_in,
  input  logic [ADDR_W-1:0] aluOutport_in,
  input  logic [ADDR_W-1:0] rdat2_in,
  input  regbits_t          rt_in,
  input  regbits_t          rd_in,
  input  opcode_t           InstrOp_in,
  input  logic              MemToReg_in,
  input  logic              RegDst_in,
  input  logic              JType_in,
  input  logic              regWEN_in,
  input  logic              Halt_in,
  input  logic              dMemREN_in,
  input  logic              dMemWEN_in,
  input  logic              flush,
  mem_stage_if.master       dcif,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] wb_dat_out,
  output regbits_t          wsel_out,
  output logic              regWEN_out,
  output logic              halt
);
  memstate_t         r_state, w_next;
  logic              r_halt, r_regwen;
  regbits_t          r_wsel;
  logic [ADDR_W-1:0] r_wb_dat;
  logic              w_live, w_issue, w_sc_block, w_wb_en;
  regbits_t          w_wsel;
  logic [ADDR_W-1:0] w_wb_dat;

  // Flush only kills in RUN; once in WAIT the outstanding request must finish.
  assign w_live = (r_state != HALTED) && !(flush && r_state == RUN);

`ifdef MEM_STAGE_LLSC_EN
  logic w_link_match;

  link_reg #(.ADDR_W(ADDR_W)) u_link_reg (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_set       (dcif.dmemREN && dcif.dhit && InstrOp_in == LL),
    .i_clr       (w_live && !mem_stall && InstrOp_in == SC),
    .i_clr_match (dcif.dmemWEN && dcif.dhit && InstrOp_in == SW),
    .i_addr      (aluOutport_in),
    .o_match     (w_link_match)
  );

  assign w_sc_block = (InstrOp_in == SC) && !w_link_match;
`else
  assign w_sc_block = 1'b0;
`endif

  // nRST gates the request so reset drops it without waiting for an edge.
  assign w_issue        = nRST && w_live && (dMemREN_in || dMemWEN_in) && !w_sc_block;
  assign dcif.dmemWEN   = w_issue && dMemWEN_in;
  assign dcif.dmemREN   = w_issue && dMemREN_in && !dMemWEN_in;
  assign dcif.dmemaddr  = aluOutport_in;
  assign dcif.dmemstore = rdat2_in;
  assign mem_stall      = (dcif.dmemREN || dcif.dmemWEN) && !dcif.dhit;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN: begin
        if (Halt_in && !flush && !mem_stall) w_next = HALTED;
        else if (mem_stall)                  w_next = WAIT;
      end
      WAIT: begin
        if (!mem_stall) w_next = Halt_in ? HALTED : RUN;
      end
      HALTED:  w_next = HALTED;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    w_wsel   = JType_in ? LINK_REGNUM : (RegDst_in ? rd_in : rt_in);
    w_wb_dat = JType_in ? pcplus4_in : (MemToReg_in ? dcif.dmemload : aluOutport_in);
    w_wb_en  = regWEN_in && w_live;
`ifdef MEM_STAGE_LLSC_EN
    if (InstrOp_in == SC) w_wb_dat = ADDR_W'(w_link_match);
`else
    if (InstrOp_in == SC) w_wb_en = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halt   <= 1'b0;
      r_regwen <= 1'b0;
      r_wsel   <= '0;
      r_wb_dat <= '0;
    end else begin
      if (w_next == HALTED) r_halt <= 1'b1;
      if (mem_stall) begin
        r_regwen <= 1'b0;
      end else begin
        r_regwen <= w_wb_en;
        r_wsel   <= w_wsel;
        r_wb_dat <= w_wb_dat;
      end
    end
  end

  assign wb_dat_out = r_wb_dat;
  assign wsel_out   = r_wsel;
  assign regWEN_out = r_regwen;
  assign halt       = r_halt;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected cache
// requests and write-backs; a negedge monitor pops and compares them.
module tb_mem_stage;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } req_t;

  typedef struct packed {
    logic [4:0]  wsel;
    logic [31:0] dat;
  } wb_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pcplus4_in, aluOutport_in, rdat2_in;
  regbits_t    rt_in, rd_in;
  opcode_t     InstrOp_in;
  logic        MemToReg_in, RegDst_in, JType_in, regWEN_in, Halt_in;
  logic        dMemREN_in, dMemWEN_in, flush;
  logic        mem_stall, regWEN_out, halt;
  logic [31:0] wb_dat_out;
  regbits_t    wsel_out;

  mem_stage_if #(.ADDR_W(32)) dc ();

  mem_stage #(.ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .pcplus4_in(pcplus4_in), .aluOutport_in(aluOutport_in), .rdat2_in(rdat2_in),
    .rt_in(rt_in), .rd_in(rd_in), .InstrOp_in(InstrOp_in),
    .MemToReg_in(MemToReg_in), .RegDst_in(RegDst_in), .JType_in(JType_in),
    .regWEN_in(regWEN_in), .Halt_in(Halt_in), .dMemREN_in(dMemREN_in),
    .dMemWEN_in(dMemWEN_in), .flush(flush), .dcif(dc.master),
    .mem_stall(mem_stall), .wb_dat_out(wb_dat_out), .wsel_out(wsel_out),
    .regWEN_out(regWEN_out), .halt(halt)
  );

  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;
  int   ren_cnt = 0;
  int   wen_cnt = 0;
  req_t req_q[$];
  wb_t  wb_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic exp_req(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] s);
    req_t r;
    r.ren = ren; r.wen = wen; r.addr = a; r.store = s;
    req_q.push_back(r);
  endtask

  task automatic exp_wb(input logic [4:0] sel, input logic [31:0] d);
    wb_t w;
    w.wsel = sel; w.dat = d;
    wb_q.push_back(w);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble();
    pcplus4_in = '0; aluOutport_in = '0; rdat2_in = '0;
    rt_in = '0; rd_in = '0; InstrOp_in = RTYPE;
    MemToReg_in = 0; RegDst_in = 0; JType_in = 0; regWEN_in = 0; Halt_in = 0;
    dMemREN_in = 0; dMemWEN_in = 0; flush = 0;
    dc.dhit = 0; dc.dmemload = '0;
  endtask

  // Monitor: a completed request (request & dhit) and a write-back (regWEN_out) each pop one entry.
  always @(negedge CLK) begin
    if (nRST) begin
      if (mem_stall)  stall_cnt++;
      if (dc.dmemREN) ren_cnt++;
      if (dc.dmemWEN) wen_cnt++;
      if ((dc.dmemREN || dc.dmemWEN) && dc.dhit) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req_extra: got ren=%b wen=%b addr=%h, want no request",
                   dc.dmemREN, dc.dmemWEN, dc.dmemaddr);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_ctl",   {dc.dmemREN, dc.dmemWEN}, {e.ren, e.wen});
          chk("req_addr",  dc.dmemaddr,  e.addr);
          chk("req_store", dc.dmemstore, e.store);
        end
      end
      if (regWEN_out) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_extra: got wsel=%0d dat=%h, want no write-back", wsel_out, wb_dat_out);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          chk("wb_wsel", wsel_out,   e.wsel);
          chk("wb_dat",  wb_dat_out, e.dat);
        end
      end
    end
  end

  initial begin
    int s0, r0, w0;
    nRST = 0;
    bubble();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_outs", {dc.dmemREN, dc.dmemWEN, mem_stall, regWEN_out, halt}, 5'b0);
    chk("rst_wb",   {wsel_out, wb_dat_out}, '0);
    nRST = 1;
    step();

    // LW with dhit three cycles late
    InstrOp_in = LW; dMemREN_in = 1; aluOutport_in = 32'h40; MemToReg_in = 1;
    rt_in = 5; regWEN_in = 1;
    exp_req(1, 0, 32'h40, 32'h0);
    exp_wb(5, 32'hDEADBEEF);
    s0 = stall_cnt; r0 = ren_cnt;
    repeat (3) step();
    dc.dhit = 1; dc.dmemload = 32'hDEADBEEF;
    step();
    bubble();
    chk("lw_stall_cycles", stall_cnt - s0, 3);
    chk("lw_ren_cycles",   ren_cnt - r0,   4);
    step();

    // SW, same-cycle dhit
    InstrOp_in = SW; dMemWEN_in = 1; aluOutport_in = 32'h44; rdat2_in = 32'h1234; dc.dhit = 1;
    exp_req(0, 1, 32'h44, 32'h1234);
    s0 = stall_cnt; w0 = wen_cnt;
    step();
    bubble();
    chk("sw_regwen", regWEN_out, 0);
    step();
    chk("sw_stall_cycles", stall_cnt - s0, 0);
    chk("sw_wen_cycles",   wen_cnt - w0,   1);

    // JAL, R-type, write to r0
    JType_in = 1; regWEN_in = 1; pcplus4_in = 32'h104; rd_in = 7; RegDst_in = 1; aluOutport_in = 32'h55;
    exp_wb(31, 32'h104);
    step(); bubble();
    regWEN_in = 1; RegDst_in = 1; rd_in = 9; rt_in = 2; aluOutport_in = 32'hABCD;
    exp_wb(9, 32'hABCD);
    step(); bubble();
    regWEN_in = 1; RegDst_in = 1; rd_in = 0; aluOutport_in = 32'h3C;
    exp_wb(0, 32'h3C);
    step(); bubble();

    // Flushed ALU op and flushed LW: no write-back, no request
    regWEN_in = 1; RegDst_in = 1; rd_in = 12; aluOutport_in = 32'h77; flush = 1;
    step(); bubble();
    InstrOp_in = LW; dMemREN_in = 1; aluOutport_in = 32'h50; flush = 1; MemToReg_in = 1; regWEN_in = 1;
    #1;
    chk("flush_lw_req", {dc.dmemREN, mem_stall}, 2'b00);
    step(); bubble();

    // REN and WEN both set: WEN wins
    InstrOp_in = SW; dMemREN_in = 1; dMemWEN_in = 1; aluOutport_in = 32'h60; rdat2_in = 32'h77; dc.dhit = 1;
    exp_req(0, 1, 32'h60, 32'h77);
    step(); bubble();

    // Flush arriving during WAIT is ignored
    InstrOp_in = LW; dMemREN_in = 1; aluOutport_in = 32'h48; MemToReg_in = 1; rt_in = 6; regWEN_in = 1;
    exp_req(1, 0, 32'h48, 32'h0);
    exp_wb(6, 32'h11);
    step();
    flush = 1;
    #1;
    chk("wait_flush_req", {dc.dmemREN, mem_stall}, 2'b11);
    step();
    dc.dhit = 1; dc.dmemload = 32'h11;
    step(); bubble();
    step();

    // LL/SC
`ifdef MEM_STAGE_LLSC_EN
    InstrOp_in = LL; dMemREN_in = 1; aluOutport_in = 32'h80; MemToReg_in = 1; rt_in = 3; regWEN_in = 1;
    dc.dhit = 1; dc.dmemload = 32'h99;
    exp_req(1, 0, 32'h80, 32'h0); exp_wb(3, 32'h99);
    step(); bubble();
    InstrOp_in = SC; dMemWEN_in = 1; aluOutport_in = 32'h80; rdat2_in = 32'h5A; rt_in = 4; regWEN_in = 1;
    dc.dhit = 1;
    exp_req(0, 1, 32'h80, 32'h5A); exp_wb(4, 32'h1);
    step(); bubble();
    InstrOp_in = LL; dMemREN_in = 1; aluOutport_in = 32'h80; MemToReg_in = 1; rt_in = 3; regWEN_in = 1;
    dc.dhit = 1; dc.dmemload = 32'h99;
    exp_req(1, 0, 32'h80, 32'h0); exp_wb(3, 32'h99);
    step(); bubble();
    InstrOp_in = SW; dMemWEN_in = 1; aluOutport_in = 32'h80; rdat2_in = 32'h33; dc.dhit = 1;
    exp_req(0, 1, 32'h80, 32'h33);
    step(); bubble();
    InstrOp_in = SC; dMemWEN_in = 1; aluOutport_in = 32'h80; rdat2_in = 32'h5A; rt_in = 4; regWEN_in = 1;
    exp_wb(4, 32'h0);
    #1;
    chk("sc_fail_req", {dc.dmemWEN, mem_stall}, 2'b00);
    step(); bubble();
`else
    InstrOp_in = LL; dMemREN_in = 1; aluOutport_in = 32'h80; MemToReg_in = 1; rt_in = 3; regWEN_in = 1;
    dc.dhit = 1; dc.dmemload = 32'h99;
    exp_req(1, 0, 32'h80, 32'h0); exp_wb(3, 32'h99);
    step(); bubble();
    InstrOp_in = SC; dMemWEN_in = 1; aluOutport_in = 32'h80; rdat2_in = 32'h5A; rt_in = 4; regWEN_in = 1;
    dc.dhit = 1;
    exp_req(0, 1, 32'h80, 32'h5A);
    step(); bubble();
    chk("sc_regwen", regWEN_out, 0);
`endif
    step();

    // Halt: sticky, blocks later requests and write-backs
    Halt_in = 1;
    #1;
    chk("halt_before_edge", halt, 0);
    step(); bubble();
    chk("halt_rise", halt, 1);
    repeat (10) step();
    chk("halt_sticky", halt, 1);
    InstrOp_in = LW; dMemREN_in = 1; aluOutport_in = 32'h40; MemToReg_in = 1; rt_in = 5; regWEN_in = 1;
    dc.dmemload = 32'hCAFE;
    #1;
    chk("halted_lw", {dc.dmemREN, mem_stall}, 2'b00);
    step(); bubble();
    chk("halted_regwen", regWEN_out, 0);

    // Reset clears halt
    nRST = 0;
    #1;
    chk("rst_halt", halt, 0);
    step();
    nRST = 1;
    step();

    // Reset asserted mid-request
    regWEN_in = 1; RegDst_in = 1; rd_in = 8; aluOutport_in = 32'h21;
    exp_wb(8, 32'h21);
    step(); bubble();
    InstrOp_in = LW; dMemREN_in = 1; aluOutport_in = 32'h90; MemToReg_in = 1; rt_in = 5; regWEN_in = 1;
    step(); step();
    chk("wait_req", {dc.dmemREN, mem_stall}, 2'b11);
    nRST = 0;
    #1;
    chk("midreq_rst", {dc.dmemREN, dc.dmemWEN, mem_stall, halt, regWEN_out}, 5'b0);
    chk("midreq_rst_wb", {wsel_out, wb_dat_out}, '0);
    step(); bubble();
    nRST = 1;
    repeat (3) step();

    chk("req_q_drained", req_q.size(), 0);
    chk("wb_q_drained",  wb_q.size(),  0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
